// File: rtl/rmac_pkg.sv
// rmac_pkg: definitions shared by the rmac datapath and its operand feeder.
//   RMAC_WIDTH / RMAC_INT_BITS / RMAC_FRAC_BITS : default Q-format operand geometry
//   RMAC_ONE                                    : fixed-point 1.0 in the default format
//   rmac_state_t                                : feeder sequencing states
package rmac_pkg;

  localparam int RMAC_WIDTH     = 32;
  localparam int RMAC_INT_BITS  = 12;
  localparam int RMAC_FRAC_BITS = 20;

  localparam logic [RMAC_WIDTH-1:0] RMAC_ONE = RMAC_WIDTH'(1) << RMAC_FRAC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } rmac_state_t;

endpackage

// File: rtl/rmac_feeder.sv
// rmac_feeder: operand sequencer in front of the rmac multiply-accumulate stage.
// Holds one neuron's weight and input vectors, and on start streams the
// (W, X) pairs one per clock. finished marks the final pair, done pulses
// one cycle later.
//
// Optional feature macro: RMAC_FEEDER_BIAS_EN
//   When defined, adds a bias register (wr_sel=0, wr_addr=N). A trailing pair
//   (bias, 1.0) is streamed after the N data pairs.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears buffers and outputs)
//   wr_en     in   buffer write strobe, honoured only while idle
//   wr_sel    in   0 = weight buffer, 1 = input buffer
//   wr_addr   in   entry index; N addresses the bias slot
//   wr_data   in   value written
//   start     in   request to stream one neuron (ignored unless idle)
//   busy      out  high from the first streamed pair through the done cycle
//   W, X      out  operand pair to rmac (zero when not streaming)
//   finished  out  high only with the last pair
//   done      out  one-cycle completion pulse
module rmac_feeder #(
  parameter int N         = 8,
  parameter int WIDTH     = rmac_pkg::RMAC_WIDTH,
  parameter int INT_BITS  = rmac_pkg::RMAC_INT_BITS,
  parameter int FRAC_BITS = rmac_pkg::RMAC_FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N):0]   wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic [WIDTH-1:0]     W,
  output logic [WIDTH-1:0]     X,
  output logic                 finished,
  output logic                 done
);

  import rmac_pkg::*;

  localparam int AW = $clog2(N) + 1;  // address / index width, reaches N
  localparam int LW = $clog2(N);      // width of a data-entry index

`ifdef RMAC_FEEDER_BIAS_EN
  localparam int LAST = N;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;
`else
  localparam int LAST = N - 1;
`endif

  localparam logic [AW-1:0] ADDR_N   = AW'(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(LAST);

  if (N < 2) begin : g_bad_n
    $error("rmac_feeder: N must be at least 2");
  end
  if (INT_BITS + FRAC_BITS != WIDTH) begin : g_bad_fmt
    $error("rmac_feeder: INT_BITS + FRAC_BITS must equal WIDTH");
  end

  // ---------------------------------------------------------------------------
  // Operand buffers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_wbuf [N];
  logic [WIDTH-1:0] r_xbuf [N];

  rmac_state_t      r_state;
  rmac_state_t      w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;

  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_x;
  logic             r_finished;
  logic             r_done;
  logic             r_busy;

  logic [WIDTH-1:0] w_w_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic             w_finished_nxt;
  logic             w_done_nxt;
  logic             w_busy_nxt;

  logic             w_wr_ok;
  logic             w_addr_data;
  logic [LW-1:0]    w_addr_lo;
  logic [LW-1:0]    w_idx_lo;

  // The done cycle is already IDLE in the state register but still reports
  // busy, so writes are also gated on the registered busy flag.
  assign w_wr_ok     = wr_en && (r_state == ST_IDLE) && !r_busy;
  assign w_addr_data = (wr_addr < ADDR_N);
  assign w_addr_lo   = wr_addr[LW-1:0];
  assign w_idx_lo    = r_idx[LW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_wbuf[i] <= '0;
        r_xbuf[i] <= '0;
      end
    end else if (w_wr_ok && w_addr_data) begin
      if (wr_sel) r_xbuf[w_addr_lo] <= wr_data;
      else        r_wbuf[w_addr_lo] <= wr_data;
    end
  end

`ifdef RMAC_FEEDER_BIAS_EN
  logic [WIDTH-1:0] r_bbuf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bbuf <= '0;
    end else if (w_wr_ok && !wr_sel && (wr_addr == ADDR_N)) begin
      r_bbuf <= wr_data;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequencer: next state plus the values the output registers load next
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_w_nxt        = '0;
    w_x_nxt        = '0;
    w_finished_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_busy_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_STREAM;
          w_idx_nxt   = '0;
        end
      end

      ST_STREAM: begin
        w_busy_nxt = 1'b1;
`ifdef RMAC_FEEDER_BIAS_EN
        if (r_idx == ADDR_N) begin
          w_w_nxt = r_bbuf;
          w_x_nxt = ONE;
        end else begin
          w_w_nxt = r_wbuf[w_idx_lo];
          w_x_nxt = r_xbuf[w_idx_lo];
        end
`else
        w_w_nxt = r_wbuf[w_idx_lo];
        w_x_nxt = r_xbuf[w_idx_lo];
`endif
        if (r_idx == LAST_IDX) begin
          w_finished_nxt = 1'b1;
          w_state_nxt    = ST_DONE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end

      ST_DONE: begin
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_w        <= '0;
      r_x        <= '0;
      r_finished <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_w        <= w_w_nxt;
      r_x        <= w_x_nxt;
      r_finished <= w_finished_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign W        = r_w;
  assign X        = r_x;
  assign finished = r_finished;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_rmac_feeder.sv
// tb_rmac_feeder: directed, table-driven bench for rmac_feeder (N=8, Q12.20).
// Honours RMAC_FEEDER_BIAS_EN in the same way as the design.
module tb_rmac_feeder;

  localparam int N = 8;
`ifdef RMAC_FEEDER_BIAS_EN
  localparam int NP = N + 1;
`else
  localparam int NP = N;
`endif
  localparam logic [31:0] ONE  = 32'h0010_0000;
  localparam logic [31:0] HALF = 32'h0008_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        busy;
  logic [31:0] W;
  logic [31:0] X;
  logic        finished;
  logic        done;

  rmac_feeder #(.N(N), .WIDTH(32), .INT_BITS(12), .FRAC_BITS(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .W        (W),
    .X        (X),
    .finished (finished),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] x;
    logic        fin;
    logic        dn;
    logic        bsy;
  } vec_t;

  vec_t tab [NP+2];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Expected per-cycle outputs after start: entries 0..NP-1 are pairs,
  // NP is the done cycle, NP+1 is back in idle.
  task automatic fill_tab(input bit loaded);
    for (int c = 0; c < NP + 2; c++) begin
      tab[c].w   = '0;
      tab[c].x   = '0;
      tab[c].fin = 1'b0;
      tab[c].dn  = 1'b0;
      tab[c].bsy = 1'b0;
      if (c < N) begin
        tab[c].w   = loaded ? ONE : 32'h0;
        tab[c].x   = loaded ? (32'(c) << 20) : 32'h0;
        tab[c].bsy = 1'b1;
      end else if (c < NP) begin
        tab[c].w   = loaded ? HALF : 32'h0;
        tab[c].x   = ONE;
        tab[c].bsy = 1'b1;
      end else if (c == NP) begin
        tab[c].dn  = 1'b1;
        tab[c].bsy = 1'b1;
      end
      if (c == NP - 1) tab[c].fin = 1'b1;
    end
  endtask

  task automatic run_check(input string tag, input longint exp_sum);
    longint acc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_after_start_edge"}, 64'(busy), 64'd0);
    for (int c = 0; c < NP + 2; c++) begin
      tick();
      chk($sformatf("%s W[%0d]", tag, c),   64'(W),        64'(tab[c].w));
      chk($sformatf("%s X[%0d]", tag, c),   64'(X),        64'(tab[c].x));
      chk($sformatf("%s fin[%0d]", tag, c), 64'(finished), 64'(tab[c].fin));
      chk($sformatf("%s done[%0d]", tag, c),64'(done),     64'(tab[c].dn));
      chk($sformatf("%s busy[%0d]", tag, c),64'(busy),     64'(tab[c].bsy));
      if (busy && !done)
        acc += (longint'($signed(W)) * longint'($signed(X))) >>> 20;
    end
    chk({tag, " sum"}, 64'(acc), 64'(exp_sum));
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    chk("drain_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int     n_done;
    int     n_busy;
    longint exp_sum;
    bit     got_done;

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst W", 64'(W), 64'd0);
    chk("rst X", 64'(X), 64'd0);
    chk("rst finished", 64'(finished), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);

    // Load vectors; bias slot write and out-of-range write (addr 9 would alias
    // entry 1 if the range check failed).
    for (int i = 0; i < N; i++) begin
      wr(1'b0, 4'(i), ONE);
      wr(1'b1, 4'(i), 32'(i) << 20);
    end
    wr(1'b0, 4'(N), HALF);
    wr(1'b1, 4'(N), 32'hDEAD_BEEF);
    wr(1'b0, 4'(N + 1), 32'hDEAD_BEEF);

`ifdef RMAC_FEEDER_BIAS_EN
    exp_sum = 64'h01C8_0000;
`else
    exp_sum = 64'h01C0_0000;
`endif
    fill_tab(1'b1);
    run_check("run1", exp_sum);

    // Restart and write attempt while streaming: both must be dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) n_done++;
      if (busy) n_busy++;
      if (c == 3) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    chk("restart done_count", 64'(n_done), 64'd1);
    chk("restart busy_cycles", 64'(n_busy), 64'(NP + 1));
    run_check("run2", exp_sum);

    // Reset mid-stream at the cycle-4 pair.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("pre_rst W", 64'(W), 64'(ONE));
    chk("pre_rst X", 64'(X), 64'(32'd3 << 20));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst W", 64'(W), 64'd0);
    chk("midrst X", 64'(X), 64'd0);
    chk("midrst finished", 64'(finished), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done || busy) n_done++;
    end
    chk("midrst no_activity", 64'(n_done), 64'd0);
    fill_tab(1'b0);
    run_check("run_cleared", 64'd0);

    // Write and start in the same cycle; then back-to-back start in done cycle.
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'hFFF0_0000; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    tick();
    chk("wrstart W0", 64'(W), 64'h0000_0000_FFF0_0000);
    chk("wrstart X0", 64'(X), 64'd0);
    chk("wrstart busy", 64'(busy), 64'd1);
    got_done = 1'b0;
    for (int k = 0; k < NP + 4 && !got_done; k++) begin
      tick();
      if (done) got_done = 1'b1;
    end
    chk("wrstart done_seen", 64'(got_done), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b gap busy", 64'(busy), 64'd0);
    tick();
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b W0", 64'(W), 64'h0000_0000_FFF0_0000);
    chk("b2b fin0", 64'(finished), 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
